// File: rtl/fft_cmul_seq_if.sv
// fft_cmul_seq_if: upstream, multiplier and downstream signals of the complex-multiply sequencer.
// Latency: none, wiring only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes unchanged.
interface fft_cmul_seq_if #(
  parameter int DW = 12,
  parameter int PW = 24
);
  // Upstream transaction: one complex sample plus one twiddle
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_re;
  logic signed [DW-1:0] x_im;
  logic signed [DW-1:0] w_re;
  logic signed [DW-1:0] w_im;
  // Shared Booth multiplier
  logic                 mul_en;
  logic signed [DW-1:0] mul_a;
  logic signed [DW-1:0] mul_b;
  logic signed [PW-1:0] mul_result;
  logic                 mul_rdy;
  // Downstream result
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;

  // Sequencer side
  modport slave (
    input  in_valid, x_re, x_im, w_re, w_im,
    output in_ready,
    output mul_en, mul_a, mul_b,
    input  mul_result, mul_rdy,
    output out_valid, out_re, out_im,
    input  out_ready
  );

  // Environment side: upstream source, multiplier and downstream sink
  modport master (
    output in_valid, x_re, x_im, w_re, w_im,
    input  in_ready,
    input  mul_en, mul_a, mul_b,
    output mul_result, mul_rdy,
    input  out_valid, out_re, out_im,
    output out_ready
  );
endinterface

// File: rtl/fft_cmul_seq.sv
// fft_cmul_seq: x*w complex multiply issued as four real products on a shared multiplier.
// Latency: out_valid 4*(L+1)+1 cycles after accept for multiplier latency L; one transaction in flight.
// Backpressure: result and in_ready=0 held until out_ready; CMUL_SAT_EN selects saturation over wrap.
module fft_cmul_seq #(
  parameter int DW   = 12,
  parameter int PW   = 24,
  parameter int FRAC = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_cmul_seq_if.slave bus
);

  localparam int AW = PW + 1;
  localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC - 1);
`ifdef CMUL_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (DW - 1)));
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t               r_state;
  logic [1:0]           r_k;
  logic signed [DW-1:0] r_x_re, r_x_im, r_w_re, r_w_im;
  logic signed [AW-1:0] r_acc_re, r_acc_im;
  logic                 r_in_ready, r_mul_en, r_out_valid;
  logic signed [DW-1:0] r_mul_a, r_mul_b, r_out_re, r_out_im;

  logic signed [AW-1:0] w_p, w_acc_re_nxt, w_acc_im_nxt;
  logic signed [DW-1:0] w_src_x_re, w_src_x_im, w_src_w_re, w_src_w_im;
  logic signed [DW-1:0] w_nxt_a, w_nxt_b;
  logic [1:0]           w_nxt_k;

  // Round half up at the Q1.11 point, then saturate or wrap to DW bits
  function automatic logic signed [DW-1:0] round_res(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] q;
    q = (acc + RND) >>> FRAC;
`ifdef CMUL_SAT_EN
    if (q > SAT_MAX) begin
      q = SAT_MAX;
    end else if (q < SAT_MIN) begin
      q = SAT_MIN;
    end
`endif
    return DW'(q);
  endfunction

  // Accumulator update for the returning product: re gets +xr*wr -xi*wi, im gets both cross terms
  always_comb begin
    w_p          = {bus.mul_result[PW-1], bus.mul_result};
    w_acc_re_nxt = r_acc_re;
    w_acc_im_nxt = r_acc_im;
    case (r_k)
      2'd0:    w_acc_re_nxt = r_acc_re + w_p;
      2'd1:    w_acc_re_nxt = r_acc_re - w_p;
      default: w_acc_im_nxt = r_acc_im + w_p;
    endcase
  end

  // Operand pair for the next issue: IDLE takes the incoming sample at k=0, WAIT the latched one at k+1
  always_comb begin
    w_src_x_re = r_x_re;
    w_src_x_im = r_x_im;
    w_src_w_re = r_w_re;
    w_src_w_im = r_w_im;
    w_nxt_k    = r_k + 2'd1;
    if (r_state == S_IDLE) begin
      w_src_x_re = bus.x_re;
      w_src_x_im = bus.x_im;
      w_src_w_re = bus.w_re;
      w_src_w_im = bus.w_im;
      w_nxt_k    = 2'd0;
    end
    w_nxt_a = w_src_x_re;
    w_nxt_b = w_src_w_re;
    case (w_nxt_k)
      2'd0: begin
        w_nxt_a = w_src_x_re;
        w_nxt_b = w_src_w_re;
      end
      2'd1: begin
        w_nxt_a = w_src_x_im;
        w_nxt_b = w_src_w_im;
      end
      2'd2: begin
        w_nxt_a = w_src_x_re;
        w_nxt_b = w_src_w_im;
      end
      default: begin
        w_nxt_a = w_src_x_im;
        w_nxt_b = w_src_w_re;
      end
    endcase
  end

  // Sequencer FSM; every output is a register so mul_en is a clean one-cycle pulse in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_x_re      <= '0;
      r_x_im      <= '0;
      r_w_re      <= '0;
      r_w_im      <= '0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_in_ready  <= 1'b1;
      r_mul_en    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_mul_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x_re     <= bus.x_re;
            r_x_im     <= bus.x_im;
            r_w_re     <= bus.w_re;
            r_w_im     <= bus.w_im;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_k        <= 2'd0;
            r_mul_a    <= w_nxt_a;
            r_mul_b    <= w_nxt_b;
            r_mul_en   <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_rdy) begin
            r_acc_re <= w_acc_re_nxt;
            r_acc_im <= w_acc_im_nxt;
            if (r_k == 2'd3) begin
              r_out_re    <= round_res(w_acc_re_nxt);
              r_out_im    <= round_res(w_acc_im_nxt);
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_k      <= w_nxt_k;
              r_mul_a  <= w_nxt_a;
              r_mul_b  <= w_nxt_b;
              r_mul_en <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mul_en    = r_mul_en;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;

endmodule
